// File: rtl/delay_reg_en_unify_pkg.sv
// Shared helpers for the delay_reg_en_unify delay line.
// Holds the tap-slice arithmetic so every user of the flattened tap bus
// locates tap k the same way.
package delay_reg_en_unify_pkg;

  // Lowest bit index of tap k inside a flattened bus of WIDTH-bit taps.
  function automatic int tap_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/delay_reg_en_unify_stage.sv
// delay_reg_stage: one WIDTH-bit enabled register with async active-low reset.
// Ports: CLK_I clock, RSTN_I async reset (active low), EN_I load enable,
//        D_I next sample, Q_O registered sample (RESET_VAL after reset).
module delay_reg_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK_I,
  input  logic             RSTN_I,
  input  logic             EN_I,
  input  logic [WIDTH-1:0] D_I,
  output logic [WIDTH-1:0] Q_O
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Hold when disabled; a disabled edge leaves the stage untouched.
  always_comb begin
    q_d = q_q;
    if (EN_I) begin
      q_d = D_I;
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q_O = q_q;

endmodule

// File: rtl/delay_reg_en_unify.sv
// delay_reg_en_unify: LEN-stage enabled shift-register delay line exposing all taps.
// Ports: CLK_I, RSTN_I (async active low), EN_I shift enable, IN_I sample (tap 0),
//        OUT_NEW2OLD_O all taps flattened (tap k at bits [(k+1)*WIDTH-1:k*WIDTH]),
//        OUT_O oldest tap. Optional macro DELAY_REG_VALID_EN adds VLD_I,
//        VLD_NEW2OLD_O and VLD_O: a parallel valid chain that resets to 0.
module delay_reg_en_unify
  import delay_reg_en_unify_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LEN       = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       CLK_I,
  input  logic                       RSTN_I,
  input  logic                       EN_I,
  input  logic [WIDTH-1:0]           IN_I,
`ifdef DELAY_REG_VALID_EN
  input  logic                       VLD_I,
  output logic [LEN:0]               VLD_NEW2OLD_O,
  output logic                       VLD_O,
`endif
  output logic [WIDTH*(LEN+1)-1:0]   OUT_NEW2OLD_O,
  output logic [WIDTH-1:0]           OUT_O
);

  // tap[0] is the live input; tap[k] is the output of stage k.
  logic [WIDTH-1:0] tap [LEN+1];

  assign tap[0] = IN_I;

  for (genvar k = 1; k <= LEN; k++) begin : g_stage
    delay_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .CLK_I  (CLK_I),
      .RSTN_I (RSTN_I),
      .EN_I   (EN_I),
      .D_I    (tap[k-1]),
      .Q_O    (tap[k])
    );
  end

  for (genvar k = 0; k <= LEN; k++) begin : g_pack
    assign OUT_NEW2OLD_O[tap_lsb(k, WIDTH) +: WIDTH] = tap[k];
  end

  assign OUT_O = tap[LEN];

`ifdef DELAY_REG_VALID_EN
  // Valid chain shifts with the data so reset fill is distinguishable.
  logic vtap [LEN+1];

  assign vtap[0] = VLD_I;

  for (genvar k = 1; k <= LEN; k++) begin : g_vstage
    delay_reg_stage #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
    ) u_vstage (
      .CLK_I  (CLK_I),
      .RSTN_I (RSTN_I),
      .EN_I   (EN_I),
      .D_I    (vtap[k-1]),
      .Q_O    (vtap[k])
    );
  end

  for (genvar k = 0; k <= LEN; k++) begin : g_vpack
    assign VLD_NEW2OLD_O[k] = vtap[k];
  end

  assign VLD_O = vtap[LEN];
`endif

  // With no stages the clock, reset and enable have nothing to drive.
  if (LEN == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{CLK_I, RSTN_I, EN_I};
  end

endmodule

// File: tb/tb_delay_reg_en_unify.sv
// Scoreboard bench: stimulus pushes expected tap buses computed from a
// history-queue model; a negedge monitor pops and compares against three
// instances (LEN=0, 1, 3).
module tb_delay_reg_en_unify;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic       vld;
  logic [7:0] din;

  always #20 clk = ~clk;

  logic [7:0]  bus0, out0;
  logic [15:0] bus1;
  logic [7:0]  out1;
  logic [31:0] bus3;
  logic [7:0]  out3;
`ifdef DELAY_REG_VALID_EN
  logic [0:0] vbus0;
  logic       vout0;
  logic [1:0] vbus1;
  logic       vout1;
  logic [3:0] vbus3;
  logic       vout3;
`endif

  delay_reg_en_unify #(.WIDTH(8), .LEN(0), .RESET_VAL(8'h00)) u_len0 (
    .CLK_I(clk), .RSTN_I(rstn), .EN_I(en), .IN_I(din),
`ifdef DELAY_REG_VALID_EN
    .VLD_I(vld), .VLD_NEW2OLD_O(vbus0), .VLD_O(vout0),
`endif
    .OUT_NEW2OLD_O(bus0), .OUT_O(out0));

  delay_reg_en_unify #(.WIDTH(8), .LEN(1), .RESET_VAL(8'h00)) u_len1 (
    .CLK_I(clk), .RSTN_I(rstn), .EN_I(en), .IN_I(din),
`ifdef DELAY_REG_VALID_EN
    .VLD_I(vld), .VLD_NEW2OLD_O(vbus1), .VLD_O(vout1),
`endif
    .OUT_NEW2OLD_O(bus1), .OUT_O(out1));

  delay_reg_en_unify #(.WIDTH(8), .LEN(3), .RESET_VAL(8'h00)) u_len3 (
    .CLK_I(clk), .RSTN_I(rstn), .EN_I(en), .IN_I(din),
`ifdef DELAY_REG_VALID_EN
    .VLD_I(vld), .VLD_NEW2OLD_O(vbus3), .VLD_O(vout3),
`endif
    .OUT_NEW2OLD_O(bus3), .OUT_O(out3));

  // Reference model: history of accepted samples, newest first.
  logic [7:0] h1 [$];
  logic [7:0] h3 [$];
  logic       v1 [$];
  logic       v3 [$];

  typedef struct {
    logic [31:0] b3;
    logic [15:0] b1;
    logic [7:0]  b0;
    logic [7:0]  o3;
    logic [7:0]  o1;
    logic [7:0]  o0;
    logic [3:0]  vb3;
    logic        vo3;
    logic [1:0]  vb1;
  } exp_t;

  exp_t exq [$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    h1 = '{8'h00};
    h3 = '{8'h00, 8'h00, 8'h00};
    v1 = '{1'b0};
    v3 = '{1'b0, 1'b0, 1'b0};
  endtask

  // Apply the clock edge that just happened, using the inputs held across it.
  task automatic model_edge();
    if (rstn && en) begin
      h1.push_front(din); void'(h1.pop_back());
      h3.push_front(din); void'(h3.pop_back());
      v1.push_front(vld); void'(v1.pop_back());
      v3.push_front(vld); void'(v3.pop_back());
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.b3  = {h3[2], h3[1], h3[0], din};
    e.b1  = {h1[0], din};
    e.b0  = din;
    e.o3  = h3[2];
    e.o1  = h1[0];
    e.o0  = din;
    e.vb3 = {v3[2], v3[1], v3[0], vld};
    e.vo3 = v3[2];
    e.vb1 = {v1[0], vld};
    exq.push_back(e);
  endtask

  // One cycle: account for the past edge, drive new inputs 1ns after it,
  // and queue what the outputs must show before the next edge.
  task automatic step(input logic [7:0] d, input logic e, input logic v, input logic r);
    @(posedge clk);
    #1;
    model_edge();
    din  = d;
    en   = e;
    vld  = v;
    rstn = r;
    if (!r) model_reset();
    push_exp();
  endtask

  // Monitor: outputs are always presented; compare once per cycle at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        chk("len3_bus", bus3, e.b3);
        chk("len3_out", {24'h0, out3}, {24'h0, e.o3});
        chk("len1_bus", {16'h0, bus1}, {16'h0, e.b1});
        chk("len1_out", {24'h0, out1}, {24'h0, e.o1});
        chk("len0_bus", {24'h0, bus0}, {24'h0, e.b0});
        chk("len0_out", {24'h0, out0}, {24'h0, e.o0});
`ifdef DELAY_REG_VALID_EN
        chk("len3_vbus", {28'h0, vbus3}, {28'h0, e.vb3});
        chk("len3_vout", {31'h0, vout3}, {31'h0, e.vo3});
        chk("len1_vbus", {30'h0, vbus1}, {30'h0, e.vb1});
        chk("len1_vout", {31'h0, vout1}, {31'h0, e.vb1[1]});
        chk("len0_vout", {31'h0, vout0}, {31'h0, vld});
        chk("len0_vbus", {31'h0, vbus0}, {31'h0, vld});
`endif
      end
    end
  end

  initial begin
    int wait_cyc;
    logic [7:0] seq2 [5];
    logic [7:0] seq3 [4];
    seq2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h22};
    seq3 = '{8'h11, 8'h22, 8'h33, 8'h44};

    rstn = 1'b0;
    en   = 1'b1;
    vld  = 1'b1;
    din  = 8'h55;
    model_reset();

    // Reset held while the clock runs: stages stay at reset value.
    for (int i = 0; i < 3; i++) step(8'h55, 1'b1, 1'b1, 1'b0);

    // Directed sequence through every length.
    for (int i = 0; i < 5; i++) step(seq2[i], 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(seq3[i], 1'b1, 1'b1, 1'b1);
    step(8'h44, 1'b0, 1'b0, 1'b1);

    // Enable gating: fill, hold with FF on the input, then re-enable.
    for (int i = 0; i < 3; i++) step(seq3[i], 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(8'hFF, 1'b0, 1'b0, 1'b1);
    step(8'hFF, 1'b1, 1'b0, 1'b1);
    step(8'h01, 1'b1, 1'b1, 1'b1);

    // Mid-stream reset between edges, then refill.
    step(8'h77, 1'b1, 1'b1, 1'b0);
    step(8'h78, 1'b1, 1'b1, 1'b1);
    step(8'h79, 1'b1, 1'b0, 1'b1);

    // Randomized traffic with occasional enable drops and resets.
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 49) != 0);
    end

    // Drain the scoreboard with a bounded wait.
    wait_cyc = 0;
    while (exq.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    total++;
    if (exq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
